// File: rtl/ram_bist_ctrl_if.sv
// ram_bist_ctrl_if: single-port RAM access port, BIST controller as master
interface ram_bist_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 8
);
  logic              ram_en;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_wdata;
  logic [WIDTH-1:0]  ram_rdata;
  modport master (output ram_en, ram_wr_en, ram_addr, ram_wdata, input ram_rdata);
  modport slave  (input ram_en, ram_wr_en, ram_addr, ram_wdata, output ram_rdata);
endinterface

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: write-then-read-back RAM self test with error count and first failing address
module ram_bist_ctrl #(
  parameter int               DEPTH  = 16,
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] SEED   = WIDTH'(8'hA5),
  parameter int               ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  ram_bist_ctrl_if.master   ram,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              err_seen
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FIN} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t            state;
  logic              cmp_v;
  logic [ADDR_W-1:0] a_d;
  logic              mis;
  function automatic logic [WIDTH-1:0] pat(input logic [ADDR_W-1:0] x);
    return WIDTH'(x) ^ SEED;
  endfunction
  // ram_rdata belongs to the read issued one cycle earlier, tracked by cmp_v/a_d
  always_comb mis = cmp_v && (ram.ram_rdata != pat(a_d));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cmp_v          <= 1'b0;
      a_d            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      err_seen       <= 1'b0;
      ram.ram_en     <= 1'b0;
      ram.ram_wr_en  <= 1'b0;
      ram.ram_addr   <= '0;
      ram.ram_wdata  <= '0;
    end else begin
      cmp_v <= 1'b0;
      if (mis) begin
        err_count <= err_count + 1'b1;
        if (!err_seen) begin
          first_err_addr <= a_d;
          err_seen       <= 1'b1;
        end
      end
      case (state)
        IDLE, FIN: if (start) begin
          state          <= WRITE;
          busy           <= 1'b1;
          done           <= 1'b0;
          pass           <= 1'b0;
          err_count      <= '0;
          first_err_addr <= '0;
          err_seen       <= 1'b0;
          ram.ram_en     <= 1'b1;
          ram.ram_wr_en  <= 1'b1;
          ram.ram_addr   <= '0;
          ram.ram_wdata  <= pat('0);
        end
        WRITE: if (ram.ram_addr == LAST) begin
          state         <= READ;
          ram.ram_wr_en <= 1'b0;
          ram.ram_addr  <= '0;
          ram.ram_wdata <= '0;
        end else begin
          ram.ram_addr  <= ram.ram_addr + 1'b1;
          ram.ram_wdata <= pat(ram.ram_addr + 1'b1);
        end
        READ: begin
          cmp_v <= 1'b1;
          a_d   <= ram.ram_addr;
          if (ram.ram_addr == LAST) begin
            state        <= DRAIN;
            ram.ram_en   <= 1'b0;
            ram.ram_addr <= '0;
          end else begin
            ram.ram_addr <= ram.ram_addr + 1'b1;
          end
        end
        DRAIN: begin
          state <= FIN;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_count == '0) && !mis;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ram_bist_ctrl.md
# ram_bist_ctrl

Hardware built-in self-test initiator for the single-port RAM. On a `start` pulse it drives the RAM port as master. It writes a deterministic address-derived pattern to every location, then reads every location back and compares it against the expected value. When both passes finish it reports pass/fail, the error count and the first failing address. It sits between system control logic and the RAM port and replaces the software bench as the stimulus source in silicon.

## Interface
- `DEPTH`, 16: number of RAM words; must be a power of two, at least 2.
- `WIDTH`, 8: RAM data width in bits.
- `SEED`, 8'hA5: pattern seed.
  - Zero-extended or truncated to `WIDTH`.
- `ADDR_W`, $clog2(DEPTH): address width (derived).

Ports:
- `clk` input, 1 bit: single clock; all logic is rising-edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: begin a test; sampled only in IDLE or DONE.
- `ram_en` output, 1 bit: RAM access enable.
- `ram_wr_en` output, 1 bit: 1 = write, 0 = read; meaningful only when `ram_en` = 1.
- `ram_addr` output, `ADDR_W` bits: RAM address.
- `ram_wdata` output, `WIDTH` bits: RAM write data.
- `ram_rdata` input, `WIDTH` bits: RAM read data, valid 1 cycle after a read access.
- `busy` output, 1 bit: test in progress.
- `done` output, 1 bit: test complete; held until the next start or reset.
- `pass` output, 1 bit: valid when `done` = 1; 1 when `err_count` = 0.
- `err_count` output, `ADDR_W`+1 bits: number of mismatching locations.
- `first_err_addr` output, `ADDR_W` bits: address of the first mismatch.
- `err_seen` output, 1 bit: at least one mismatch recorded.

## Operation
- Pattern: `exp(a) = a ^ SEED`, with `a` zero-extended to `WIDTH`, or truncated to `WIDTH` when `ADDR_W` > `WIDTH`.
- IDLE
  - All RAM outputs are 0.
  - `start` = 1 → WRITE. Clear `err_count`, `first_err_addr`, `err_seen` and `done`; set `busy`.
- WRITE
  - Each cycle drive `ram_en` = 1, `ram_wr_en` = 1, `ram_addr` = `a`, `ram_wdata` = `exp(a)`.
  - `a` runs 0..DEPTH-1.
  - After `a` = DEPTH-1 → READ with `a` = 0.
- READ
  - Issue phase: each cycle drive `ram_en` = 1, `ram_wr_en` = 0, `ram_addr` = `a`, `ram_wdata` = 0.
  - Registered-address pipeline: in the cycle after each issue, compare `ram_rdata` to `exp(a_d)`, where `a_d` is the address issued in the previous cycle.
  - After issuing DEPTH-1, drain one cycle with `ram_en` = 0 for the final compare → DONE.
- Mismatch handling
  - Increment `err_count`. It cannot overflow: its maximum is DEPTH, which fits in `ADDR_W`+1 bits.
  - If `err_seen` = 0: latch `first_err_addr` = `a_d` and set `err_seen`.
  - Later mismatches never overwrite `first_err_addr`.
- DONE
  - `busy` = 0, `done` = 1, `pass` = (`err_count` == 0).
  - RAM outputs are 0.
  - `start` = 1 → WRITE, with the same clears as from IDLE.
- `start` while `busy` is ignored; no restart, no effect on counters.
- Address counter wraps only through explicit state transitions; it never free-runs past DEPTH-1.

## Timing
- Reset values:
  - State IDLE; `busy`, `done`, `pass`, `err_seen` = 0.
  - `err_count`, `first_err_addr` = 0.
  - `ram_en`, `ram_wr_en`, `ram_addr`, `ram_wdata` = 0.
- Reset asserted mid-test aborts immediately (asynchronously) to the reset values. No further RAM access occurs until a new `start`.
- All outputs are registered.
- Cycle sequence, with the `start` sampling edge = edge 0:
  - `busy` = 1 and the first write visible after edge 0.
  - Writes occupy cycles 1..DEPTH.
  - Read issues occupy cycles DEPTH+1..2·DEPTH.
  - Drain/last compare occupies cycle 2·DEPTH+1.
  - `done` = 1 and `busy` = 0 from cycle 2·DEPTH+2.
- Total start-to-done latency is 2·DEPTH+2 cycles: 34 cycles for DEPTH = 16.
- Counter updates are visible on outputs:
  - `err_count` updates the cycle after the compare.
  - `pass` is settled whenever `done` = 1.
- `start` held high continuously:
  - One test runs.
  - On reaching DONE, a new test starts at the next edge.
  - `done` is high for exactly 1 cycle between tests.

## Test plan
- **Clean RAM:** DEPTH = 16, WIDTH = 8, SEED = 8'hA5, ideal 1-cycle RAM model, `start` pulse.
  - Writes show addr 3 / data 8'hA6.
  - `done` asserts 34 cycles after the `start` edge.
  - `pass` = 1, `err_count` = 0, `err_seen` = 0.
- **Single stuck bit:** RAM model forces bit 0 = 1 at addr 5 (exp 8'hA0, reads 8'hA1).
  - `pass` = 0, `err_count` = 1, `first_err_addr` = 5.
- **Multiple faults:** model corrupts addrs 9, 2 and 15.
  - `err_count` = 3, `first_err_addr` = 2 (read order, not injection order).
- **All-fail:** model returns 8'h00 everywhere.
  - Every location mismatches because `exp(a)` is never 0 for SEED = 8'hA5, so `err_count` = 16, `first_err_addr` = 0.
  - Confirms the `ADDR_W`+1 counter width.
- **Reset mid-READ:** assert `rst` at cycle 20.
  - All outputs are 0 in the same cycle, state IDLE, no RAM access.
  - A new `start` then gives a full clean run with `pass` = 1.
- **Start handling:**
  - `start` pulse at cycle 10 during WRITE is ignored; `done` still lands at cycle 34.
  - `start` at DONE after a failing run clears `err_count`, `err_seen` and `done` on the next edge and reruns.
